// File: rtl/key_code_tone_player.sv
// Key-code note sink: debounces the code stream, decodes notes and plays a square-wave tone.
// Define KEY_NOTE_LEN_EN to build the held-length counter with its note_done/note_len report.
module key_code_tone_player #(
  parameter int unsigned CODE_STABLE = 2,
  parameter int unsigned DIV_BASE    = 4,
  parameter int unsigned DIV_STEP    = 2,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned LEN_W       = 16
) (
  input  logic             clock,
  input  logic             k_tr,
  input  logic [7:0]       key_code,
  output logic             tone_out,
  output logic [3:0]       note_idx,
  output logic             note_on,
  output logic             note_done,
  output logic [LEN_W-1:0] note_len
);

  localparam int unsigned CNT_W    = $clog2(CODE_STABLE + 1);
  localparam logic [7:0]  CODE_REL = 8'hf0;

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state, state_d;
  logic [7:0]       code_q, acc_code;
  logic [CNT_W-1:0] stable_cnt;
  logic [DIV_W-1:0] half_q, half_d, phase_q, phase_d;
  logic [3:0]       idx_d, acc_idx_c;
  logic [DIV_W-1:0] acc_half_c;
  logic             tone_d, on_d, accept_c, load_c, end_c;

  function automatic logic [3:0] decode(input logic [7:0] c);
    case (c)
      8'h2b:   decode = 4'd1;
      8'h34:   decode = 4'd2;
      8'h33:   decode = 4'd3;
      8'h3b:   decode = 4'd4;
      8'h42:   decode = 4'd5;
      8'h4b:   decode = 4'd6;
      8'h4c:   decode = 4'd7;
      8'h4a:   decode = 4'd8;
      8'h4d:   decode = 4'd9;
      8'h4e:   decode = 4'd10;
      8'h4f:   decode = 4'd11;
      8'h50:   decode = 4'd12;
      8'h51:   decode = 4'd13;
      8'h52:   decode = 4'd14;
      default: decode = 4'd0;
    endcase
  endfunction

  // Glitch filter: a new code must sit unchanged in code_q for CODE_STABLE edges
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      code_q     <= CODE_REL;
      stable_cnt <= '0;
      acc_code   <= CODE_REL;
    end else begin
      code_q <= key_code;
      if (key_code != code_q) begin
        stable_cnt <= CNT_W'(1);
      end else if (stable_cnt < CNT_W'(CODE_STABLE)) begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
      if (accept_c) begin
        acc_code <= code_q;
      end
    end
  end

  assign accept_c   = (code_q != acc_code) && (stable_cnt == CNT_W'(CODE_STABLE));
  assign acc_idx_c  = decode(code_q);
  assign acc_half_c = DIV_W'(DIV_BASE) + DIV_W'(4'd14 - acc_idx_c) * DIV_W'(DIV_STEP);

  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      state    <= IDLE;
      note_idx <= 4'd0;
      note_on  <= 1'b0;
      tone_out <= 1'b0;
      phase_q  <= '0;
      half_q   <= '0;
    end else begin
      state    <= state_d;
      note_idx <= idx_d;
      note_on  <= on_d;
      tone_out <= tone_d;
      phase_q  <= phase_d;
      half_q   <= half_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = note_idx;
    on_d    = note_on;
    tone_d  = tone_out;
    phase_d = phase_q;
    half_d  = half_q;
    load_c  = 1'b0;
    end_c   = 1'b0;
    case (state)
      IDLE: begin
        tone_d  = 1'b0;
        phase_d = '0;
        if (accept_c && acc_idx_c != 4'd0) begin
          state_d = PLAY;
          load_c  = 1'b1;
        end
      end
      PLAY: begin
        if (phase_q == half_q - DIV_W'(1)) begin
          phase_d = '0;
          tone_d  = ~tone_out;
        end else begin
          phase_d = phase_q + DIV_W'(1);
        end
        if (accept_c) begin
          end_c = 1'b1;
          if (acc_idx_c == 4'd0) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            on_d    = 1'b0;
            tone_d  = 1'b0;
            phase_d = '0;
          end else begin
            load_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // New note (from idle or retrigger) restarts the tone low at phase 0
    if (load_c) begin
      idx_d   = acc_idx_c;
      half_d  = acc_half_c;
      on_d    = 1'b1;
      phase_d = '0;
      tone_d  = 1'b0;
    end
  end

`ifdef KEY_NOTE_LEN_EN
  logic [LEN_W-1:0] len_q;

  // Held-length counter, saturating; reported when the note ends
  always_ff @(posedge clock or negedge k_tr) begin
    if (!k_tr) begin
      len_q     <= '0;
      note_done <= 1'b0;
      note_len  <= '0;
    end else begin
      note_done <= end_c;
      if (end_c) begin
        note_len <= len_q;
      end
      if (load_c) begin
        len_q <= LEN_W'(1);
      end else if (state == PLAY && len_q != '1) begin
        len_q <= len_q + LEN_W'(1);
      end
    end
  end
`else
  logic unused_len_c;
  assign unused_len_c = ^{end_c, load_c};
  assign note_done    = 1'b0;
  assign note_len     = '0;
`endif

endmodule

// File: tb/tb_key_code_tone_player.sv
// Directed bench for key_code_tone_player; note-end lengths are checked through a scoreboard queue.
module tb_key_code_tone_player;

  logic        clock = 1'b0;
  logic        k_tr;
  logic [7:0]  key_code;
  logic        tone_out, note_on, note_done;
  logic [3:0]  note_idx;
  logic [15:0] note_len;
  logic        s_tone, s_on, s_done;
  logic [3:0]  s_idx;
  logic [3:0]  s_len;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_main[$];
  int q_sat[$];

  key_code_tone_player #(.LEN_W(16)) dut (
    .clock(clock), .k_tr(k_tr), .key_code(key_code), .tone_out(tone_out),
    .note_idx(note_idx), .note_on(note_on), .note_done(note_done), .note_len(note_len));

  key_code_tone_player #(.LEN_W(4)) dut_sat (
    .clock(clock), .k_tr(k_tr), .key_code(key_code), .tone_out(s_tone),
    .note_idx(s_idx), .note_on(s_on), .note_done(s_done), .note_len(s_len));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Expected note length for both instances (the small one saturates at 15)
  task automatic expect_end(input int n);
`ifdef KEY_NOTE_LEN_EN
    q_main.push_back(n);
    q_sat.push_back(n > 15 ? 15 : n);
`endif
  endtask

  task automatic measure_period(output int p);
    int t0;
    int n;
    logic prev;
    p = -1;
    t0 = -1;
    n = 0;
    prev = tone_out;
    while (n < 400 && p < 0) begin
      @(posedge clock);
      #1;
      n++;
      if (tone_out && !prev) begin
        if (t0 < 0) t0 = n;
        else p = n - t0;
      end
      prev = tone_out;
    end
  endtask

  // Scoreboard consumers: every note_done pulse must match one queued length
  always @(negedge clock) begin
    if (note_done) begin
      if (q_main.size() == 0) check("unexpected_done", 32'(note_done), 32'd0);
      else check("note_len", 32'(note_len), 32'(q_main.pop_front()));
    end
    if (s_done) begin
      if (q_sat.size() == 0) check("unexpected_done_sat", 32'(s_done), 32'd0);
      else check("note_len_sat", 32'(s_len), 32'(q_sat.pop_front()));
    end
  end

  initial begin
    int c0;
    int c1;
    int per;

    // Reset: outputs stay 0 while key_code toggles
    k_tr = 1'b0;
    key_code = 8'h2b;
    step(2);
    key_code = 8'h52;
    step(2);
    key_code = 8'h2b;
    step(3);
    check("rst_idx", 32'(note_idx), 32'd0);
    check("rst_on", 32'(note_on), 32'd0);
    check("rst_tone", 32'(tone_out), 32'd0);
    check("rst_done", 32'(note_done), 32'd0);
    check("rst_len", 32'(note_len), 32'd0);
    key_code = 8'hf0;
    step(1);
    k_tr = 1'b1;
    step(10);
    check("idle_on", 32'(note_on), 32'd0);
    check("idle_idx", 32'(note_idx), 32'd0);

    // Note 2b held 100 cycles
    key_code = 8'h2b;
    c0 = cyc;
    step(2);
    check("latency_idx", 32'(note_idx), 32'd0);
    step(1);
    check("note_idx_1", 32'(note_idx), 32'd1);
    check("note_on_1", 32'(note_on), 32'd1);
    check("tone_start", 32'(tone_out), 32'd0);
    measure_period(per);
    check("period_idx1", 32'(per), 32'd60);
    wait_until(c0 + 100);
    key_code = 8'hf0;
    expect_end(100);
    step(2);
    check("release_latency", 32'(note_on), 32'd1);
    step(1);
    check("release_on", 32'(note_on), 32'd0);
    check("release_idx", 32'(note_idx), 32'd0);
    check("release_tone", 32'(tone_out), 32'd0);
    step(5);
`ifdef KEY_NOTE_LEN_EN
    check("len_held", 32'(note_len), 32'd100);
`else
    check("len_off", 32'(note_len), 32'd0);
`endif

    // Glitch: one-cycle 34 inside the release stream
    key_code = 8'h34;
    step(1);
    key_code = 8'hf0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("glitch_on", 32'(note_on), 32'd0);
    end

    // Retrigger 2b -> 52 after 50 cycles
    key_code = 8'h2b;
    c0 = cyc;
    step(3);
    check("retrig_first", 32'(note_idx), 32'd1);
    wait_until(c0 + 50);
    key_code = 8'h52;
    c1 = cyc;
    expect_end(50);
    step(3);
    check("retrig_idx", 32'(note_idx), 32'd14);
    check("retrig_on", 32'(note_on), 32'd1);
    check("retrig_tone", 32'(tone_out), 32'd0);
    measure_period(per);
    check("period_idx14", 32'(per), 32'd8);
    wait_until(c1 + 30);
    key_code = 8'hf0;
    expect_end(30);
    step(8);

    // Saturation: 4b held 40 cycles, small instance reports 15
    key_code = 8'h4b;
    c0 = cyc;
    step(10);
    check("idx_4b", 32'(note_idx), 32'd6);
    check("idx_4b_sat", 32'(s_idx), 32'd6);
    wait_until(c0 + 40);
    key_code = 8'hf0;
    expect_end(40);
    step(6);
`ifdef KEY_NOTE_LEN_EN
    check("sat_len", 32'(s_len), 32'd15);
`else
    check("sat_len_off", 32'(s_len), 32'd0);
`endif

    // Unknown code acts as release
    key_code = 8'h33;
    c0 = cyc;
    step(5);
    check("idx_33", 32'(note_idx), 32'd3);
    wait_until(c0 + 20);
    key_code = 8'h1c;
    expect_end(20);
    step(3);
    check("unknown_off", 32'(note_on), 32'd0);
    key_code = 8'hf0;
    step(5);

    // Reset mid-note: immediate silence, no pulse
    key_code = 8'h4f;
    step(20);
    check("mid_on", 32'(note_on), 32'd1);
    #2;
    k_tr = 1'b0;
    #1;
    check("mid_rst_on", 32'(note_on), 32'd0);
    check("mid_rst_idx", 32'(note_idx), 32'd0);
    check("mid_rst_tone", 32'(tone_out), 32'd0);
    key_code = 8'hf0;
    step(3);
    k_tr = 1'b1;
    step(10);
    check("post_rst_on", 32'(note_on), 32'd0);

    check("pending_main", 32'(q_main.size()), 32'd0);
    check("pending_sat", 32'(q_sat.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
